// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the async FIFO: turns the one-cycle-latency rd/empty/dout
// port into a valid/ready stream through a 3-entry buffer. The read strobe is
// computed from registered state only, so m_ready never reaches fifo_rd.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  output logic                  fifo_rd,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] mem_q [3];
  logic [DATA_WIDTH-1:0] mem_d [3];
  logic [1:0]            wp_q, wp_d;
  logic [1:0]            rp_q, rp_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;

  logic [2:0]            cnt_sum;
  logic                  capture;
  logic                  pop;

  // Pointer increment over the 3-entry ring: 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Stream outputs: head of the buffer.
  always_comb begin
    m_valid   = (cnt_q != 2'd0);
    occupancy = cnt_q;
    case (rp_q)
      2'd1:    m_data = mem_q[1];
      2'd2:    m_data = mem_q[2];
      default: m_data = mem_q[0];
    endcase
  end

  // Read issue, capture and pop; flush overrides all of them.
  always_comb begin
    // Reserve a slot for the word already in flight before issuing another read.
    cnt_sum = {1'b0, cnt_q} + {2'b00, inflight_q};
    fifo_rd = rstn & ~flush & ~fifo_empty & (cnt_sum <= 3'd2);
    capture = inflight_q & ~flush;
    pop     = m_valid & m_ready & ~flush;
  end

  // Next-state for buffer, pointers, count and in-flight tracking.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      mem_d[i] = mem_q[i];
      if (capture && (wp_q == 2'(i))) begin
        mem_d[i] = fifo_dout;
      end
    end

    inflight_d = fifo_rd;

    if (flush) begin
      wp_d  = 2'd0;
      rp_d  = 2'd0;
      cnt_d = 2'd0;
    end else begin
      wp_d  = capture ? ptr_inc(wp_q) : wp_q;
      rp_d  = pop ? ptr_inc(rp_q) : rp_q;
      cnt_d = cnt_q;
      case ({capture, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // State registers; reset also clears the buffer so m_data reads 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= '0;
      end
      wp_q       <= 2'd0;
      rp_q       <= 2'd0;
      cnt_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a FIFO model with one-cycle read latency feeds the
// DUT; stimulus pushes expected words into a queue, a monitor pops and compares.
module tb_fifo_rd_stream;

  logic       clk;
  logic       rstn;
  logic       flush;
  logic       fifo_rd;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] occupancy;

  logic [7:0] fmem [0:4095];
  int         head;
  int         tail;
  logic       gap;

  logic [7:0] exp_q [$];
  int         n_checks;
  int         n_pass;

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .fifo_rd    (fifo_rd),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (head == tail) || gap;

  // FIFO model: dout valid the cycle after rd; reset discards its contents.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head      <= tail;
      fifo_dout <= 8'h00;
    end else if (fifo_rd && (head != tail)) begin
      fifo_dout <= fmem[head];
      head      <= head + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compare every accepted beat; catch reads issued against an empty FIFO.
  always @(negedge clk) begin
    if (rstn && fifo_rd) chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
    if (rstn && m_valid && m_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {24'd0, m_data}, 32'hffff_ffff);
      end else begin
        chk("beat", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] w, input bit expect_it);
    fmem[tail] = w;
    tail = tail + 1;
    if (expect_it) exp_q.push_back(w);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_valid"}, {31'd0, m_valid}, 32'd0);
    chk({name, "_data"}, {24'd0, m_data}, 32'd0);
    chk({name, "_occ"}, {30'd0, occupancy}, 32'd0);
    chk({name, "_rd"}, {31'd0, fifo_rd}, 32'd0);
  endtask

  initial begin
    int rd_pulses;
    int loaded;
    int found;
    n_checks = 0;
    n_pass   = 0;
    head     = 0;
    tail     = 0;
    gap      = 1'b0;
    rstn     = 1'b0;
    flush    = 1'b0;
    m_ready  = 1'b0;
    #2;
    check_idle("reset_initial");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Streaming: 16 words, m_valid two cycles after empty falls, no gaps.
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) load(8'(i), 1'b1);
    @(negedge clk) chk("stream_lat_c0", {31'd0, m_valid}, 32'd0);
    @(negedge clk) chk("stream_lat_c1", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) chk("stream_nogap", {31'd0, m_valid}, 32'd1);
    end
    @(negedge clk) chk("stream_end", {31'd0, m_valid}, 32'd0);
    chk("stream_drained", exp_q.size(), 0);

    // Mid-stream reset then idle with an empty FIFO.
    tick();
    for (int i = 0; i < 10; i++) load(8'h80 + 8'(i), 1'b1);
    repeat (5) tick();
    rstn = 1'b0;
    exp_q.delete();
    #1 check_idle("reset_mid");
    repeat (2) tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) check_idle("idle");
    end

    // Backpressure: three reads, head holds 0x01, then restart.
    tick();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) load(8'(i), 1'b1);
    rd_pulses = 0;
    repeat (10) begin
      @(negedge clk) rd_pulses += int'(fifo_rd);
    end
    chk("bp_rd_pulses", rd_pulses, 3);
    chk("bp_occ", {30'd0, occupancy}, 32'd3);
    chk("bp_valid", {31'd0, m_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) chk("bp_head_stable", {24'd0, m_data}, 32'h01);
    end
    tick();
    m_ready = 1'b1;
    @(negedge clk) chk("bp_rd_held", {31'd0, fifo_rd}, 32'd0);
    @(negedge clk) chk("bp_restart_rd", {31'd0, fifo_rd}, 32'd1);
    drain("bp_drain", 50);

    // Flush with 0x43 in flight and 0x41/0x42 buffered: next beat must be 0x44.
    tick();
    m_ready = 1'b0;
    load(8'h41, 1'b0);
    load(8'h42, 1'b0);
    load(8'h43, 1'b0);
    load(8'h44, 1'b1);
    load(8'h45, 1'b1);
    load(8'h46, 1'b1);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (occupancy == 2'd2) found = 1;
    end
    chk("flush_setup_occ", {30'd0, occupancy}, 32'd2);
    flush = 1'b1;
    @(negedge clk) chk("flush_rd_low", {31'd0, fifo_rd}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_occ", {30'd0, occupancy}, 32'd0);
    chk("flush_valid", {31'd0, m_valid}, 32'd0);
    m_ready = 1'b1;
    drain("flush_drain", 50);

    // Wrap-around: alternate ready for 20 words.
    tick();
    for (int i = 0; i < 20; i++) load(8'hc0 + 8'(i), 1'b1);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    m_ready = 1'b1;
    drain("wrap_drain", 50);

    // Random ready and empty gaps over 1000 words.
    loaded = 0;
    for (int c = 0; c < 20000 && loaded < 1000; c++) begin
      tick();
      m_ready = 1'($urandom_range(0, 1));
      gap     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        load(8'((loaded * 7 + 3) & 8'hff), 1'b1);
        loaded++;
      end
    end
    chk("rand_loaded", loaded, 1000);
    tick();
    gap     = 1'b0;
    m_ready = 1'b1;
    drain("rand_drain", 3000);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
